// File: rtl/tcore_param.sv
// -----------------------------------------------------------------------------
// tcore_param -- shared core-wide types and constants.
//
// Holds the fetch/decode hand-off types:
//   XLEN            architectural register width
//   FQ_DEPTH        default fetch queue entry count
//   exc_type_e      fetch-time exception classification (NO_EXC = no fault)
//   predict_info_t  branch prediction side-band carried with an instruction
//   fq_entry_t      one fetch queue entry {pc, inst, is_comp, exc, spec}
// -----------------------------------------------------------------------------
package tcore_param;

  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 4;

  typedef enum logic [1:0] {
    NO_EXC           = 2'd0,
    FETCH_FAULT      = 2'd1,
    ILLEGAL_INST     = 2'd2,
    FETCH_MISALIGNED = 2'd3
  } exc_type_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } predict_info_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            is_comp;
    exc_type_e       exc;
    predict_info_t   spec;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue -- decoupling FIFO between stage1_fetch and decode.
//
// Circular buffer of DEPTH entries (power of two, >= 2) with read/write
// pointers and a separate occupancy counter. Once an entry carrying a fetch
// exception is accepted, further enqueues are held off until a flush; entries
// already queued keep draining.
//
// Optional build macro:
//   FETCH_QUEUE_BYPASS_EN  when defined, an offer made while the queue is
//                          empty is presented to decode in the same cycle and
//                          is not stored if decode takes it immediately.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    redirect flush: empties the queue, clears hold
//   enq_valid_i / enq_ready_o  enqueue handshake from fetch
//   enq_pc_i, enq_inst_i, enq_is_comp_i, enq_exc_i, enq_spec_i  enqueue payload
//   deq_valid_o / deq_ready_i  dequeue handshake to decode
//   deq_pc_o, deq_inst_o, deq_is_comp_o, deq_exc_o, deq_spec_o  head payload
//                              (all zero / NO_EXC while deq_valid_o is low)
//   count_o                    number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue
  import tcore_param::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [XLEN-1:0]            enq_pc_i,
  input  logic [XLEN-1:0]            enq_inst_i,
  input  logic                       enq_is_comp_i,
  input  exc_type_e                  enq_exc_i,
  input  predict_info_t              enq_spec_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [XLEN-1:0]            deq_pc_o,
  output logic [XLEN-1:0]            deq_inst_o,
  output logic                       deq_is_comp_o,
  output exc_type_e                  deq_exc_o,
  output predict_info_t              deq_spec_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fq_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              exc_hold_q;

  fq_entry_t         enq_entry;
  fq_entry_t         deq_entry;
  logic              empty;
  logic              full;
  logic              enq_fire;
  logic              byp;
  logic              do_write;
  logic              do_read;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Depends only on registered state and flush, never on deq_ready_i.
  assign enq_ready_o = !full && !exc_hold_q && !flush_i;
  assign enq_fire    = enq_valid_i && enq_ready_o;

`ifdef FETCH_QUEUE_BYPASS_EN
  // enq_ready_o already folds in !flush_i and the exception hold, so a held
  // or flushed offer is never forwarded.
  assign byp = empty && enq_fire;
`else
  assign byp = 1'b0;
`endif

  assign deq_valid_o = (!empty && !flush_i) || byp;

  // A bypassed offer taken by decode in the same cycle is never stored.
  assign do_write = enq_fire && !(byp && deq_ready_i);
  assign do_read  = deq_valid_o && deq_ready_i && !flush_i && !byp;

  always_comb begin
    enq_entry         = '0;
    enq_entry.pc      = enq_pc_i;
    enq_entry.inst    = enq_inst_i;
    enq_entry.is_comp = enq_is_comp_i;
    enq_entry.exc     = enq_exc_i;
    enq_entry.spec    = enq_spec_i;
  end

  // Payload is forced to zero (NO_EXC) whenever nothing is presented.
  always_comb begin
    deq_entry = '0;
    if (deq_valid_o) begin
      deq_entry = empty ? enq_entry : mem[rd_ptr_q];
    end
  end

  assign deq_pc_o      = deq_entry.pc;
  assign deq_inst_o    = deq_entry.inst;
  assign deq_is_comp_o = deq_entry.is_comp;
  assign deq_exc_o     = deq_entry.exc;
  assign deq_spec_o    = deq_entry.spec;
  assign count_o       = count_q;

  // Control state: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      exc_hold_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      exc_hold_q <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_read)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_write) - CW'(do_read);
      if (enq_fire && (enq_exc_i != NO_EXC)) exc_hold_q <= 1'b1;
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_write) mem[wr_ptr_q] <= enq_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue -- randomized and directed bench for fetch_queue.
// Reference model: an SV queue of expected entries plus an exception-hold flag,
// updated from the handshake rules once per cycle; a monitor on the falling
// edge compares every DUT output against that model and pops on dequeue.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  import tcore_param::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [XLEN-1:0] enq_pc_i;
  logic [XLEN-1:0] enq_inst_i;
  logic            enq_is_comp_i;
  exc_type_e       enq_exc_i;
  predict_info_t   enq_spec_i;
  logic            deq_valid_o;
  logic            deq_ready_i;
  logic [XLEN-1:0] deq_pc_o;
  logic [XLEN-1:0] deq_inst_o;
  logic            deq_is_comp_o;
  exc_type_e       deq_exc_o;
  predict_info_t   deq_spec_o;
  logic [CW-1:0]   count_o;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i), .enq_is_comp_i(enq_is_comp_i),
    .enq_exc_i(enq_exc_i), .enq_spec_i(enq_spec_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_pc_o(deq_pc_o), .deq_inst_o(deq_inst_o), .deq_is_comp_o(deq_is_comp_o),
    .deq_exc_o(deq_exc_o), .deq_spec_o(deq_spec_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  fq_entry_t exp_q[$];
  bit        hold = 1'b0;
  bit        seen_flushed_pc = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / monitor: compares outputs against the model, then advances
  // the model by the handshake that will occur at the coming rising edge.
  always @(negedge clk_i) begin
    fq_entry_t offer, exp_ent, act_ent;
    bit exp_rdy, exp_vld, byp;
    if (!rst_ni) begin
      exp_q.delete();
      hold = 1'b0;
    end
    offer         = '0;
    offer.pc      = enq_pc_i;
    offer.inst    = enq_inst_i;
    offer.is_comp = enq_is_comp_i;
    offer.exc     = enq_exc_i;
    offer.spec    = enq_spec_i;
    exp_rdy = (exp_q.size() != DEPTH) && !hold && !flush_i;
    byp     = BYP && (exp_q.size() == 0) && enq_valid_i && exp_rdy;
    exp_vld = ((exp_q.size() != 0) && !flush_i) || byp;
    exp_ent = '0;
    if (exp_vld) exp_ent = byp ? offer : exp_q[0];
    act_ent         = '0;
    act_ent.pc      = deq_pc_o;
    act_ent.inst    = deq_inst_o;
    act_ent.is_comp = deq_is_comp_o;
    act_ent.exc     = deq_exc_o;
    act_ent.spec    = deq_spec_o;
    chk("enq_ready", 128'(enq_ready_o), 128'(exp_rdy));
    chk("deq_valid", 128'(deq_valid_o), 128'(exp_vld));
    chk("count",     128'(count_o),     128'(exp_q.size()));
    chk("payload",   128'(act_ent),     128'(exp_ent));
    if (deq_valid_o && deq_pc_o == 32'h4000_0100) seen_flushed_pc = 1'b1;
    if (rst_ni) begin
      if (flush_i) begin
        exp_q.delete();
        hold = 1'b0;
      end else begin
        if (exp_vld && deq_ready_i && !byp) void'(exp_q.pop_front());
        if (enq_valid_i && exp_rdy) begin
          if (offer.exc != NO_EXC) hold = 1'b1;
          if (!(byp && deq_ready_i)) exp_q.push_back(offer);
        end
      end
    end
  end

  task automatic apply(input logic v, input logic [31:0] pc, input exc_type_e exc,
                       input logic rdy, input logic fl);
    enq_valid_i       = v;
    enq_pc_i          = pc;
    enq_inst_i        = $urandom;
    enq_is_comp_i     = 1'($urandom_range(0, 1));
    enq_exc_i         = exc;
    enq_spec_i.taken  = 1'($urandom_range(0, 1));
    enq_spec_i.target = $urandom;
    deq_ready_i       = rdy;
    flush_i           = fl;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input exc_type_e exc,
                     input logic rdy, input logic fl);
    apply(v, pc, exc, rdy, fl);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && count_o != '0; i++) cyc(1'b0, 32'h0, NO_EXC, 1'b1, 1'b0);
    chk("drain_empty", 128'(count_o), 128'(0));
  endtask

  initial begin
    logic [31:0] pc;
    bit acc;
    rst_ni = 1'b0;
    apply(1'b0, 32'h0, NO_EXC, 1'b0, 1'b0);
    step();
    step();
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_deq_valid", 128'(deq_valid_o), 128'(0));
    rst_ni = 1'b1;

    // Fill to full with decode stalled, then a fifth offer is refused.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h4000_0000 + 32'(4*i), NO_EXC, 1'b0, 1'b0);
    chk("full_count", 128'(count_o), 128'(4));
    chk("full_enq_ready", 128'(enq_ready_o), 128'(0));
    cyc(1'b1, 32'h4000_0010, NO_EXC, 1'b0, 1'b0);
    chk("fifth_refused", 128'(count_o), 128'(4));

    // Stream through the full queue; offers held until accepted, pointers wrap.
    pc = 32'h4000_0010;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, pc, NO_EXC, 1'b1, 1'b0);
      #1;
      acc = enq_ready_o;
      step();
      if (acc) pc += 32'd4;
    end
    drain();

    // Flush with three queued and a concurrent offer.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h4000_0080 + 32'(4*i), NO_EXC, 1'b0, 1'b0);
    cyc(1'b1, 32'h4000_0100, NO_EXC, 1'b0, 1'b1);
    chk("flush_count", 128'(count_o), 128'(0));
    chk("flush_deq_valid", 128'(deq_valid_o), 128'(0));
    cyc(1'b0, 32'h0, NO_EXC, 1'b1, 1'b0);

    // Exception entry: holds fetch, drains with its exception, cleared by flush.
    cyc(1'b1, 32'h4000_0020, FETCH_FAULT, 1'b0, 1'b0);
    apply(1'b1, 32'h4000_0024, NO_EXC, 1'b0, 1'b0);
    #1;
    chk("exc_hold_ready", 128'(enq_ready_o), 128'(0));
    chk("exc_head", 128'(deq_exc_o), 128'(FETCH_FAULT));
    step();
    cyc(1'b1, 32'h4000_0028, NO_EXC, 1'b1, 1'b0);
    cyc(1'b1, 32'h4000_002C, NO_EXC, 1'b1, 1'b0);
    chk("exc_hold_after_drain", 128'(enq_ready_o), 128'(0));
    cyc(1'b0, 32'h0, NO_EXC, 1'b0, 1'b1);
    apply(1'b0, 32'h0, NO_EXC, 1'b0, 1'b0);
    #1;
    chk("exc_cleared_by_flush", 128'(enq_ready_o), 128'(1));

    // Empty queue, decode ready: latency of a single offer.
    apply(1'b1, 32'h4000_0040, NO_EXC, 1'b1, 1'b0);
    #1;
    chk("lat_same_cycle", 128'(deq_valid_o), 128'(BYP));
    step();
    apply(1'b0, 32'h0, NO_EXC, 1'b0, 1'b0);
    #1;
    chk("lat_next_cycle", 128'(deq_valid_o), 128'(!BYP));
    chk("lat_count", 128'(count_o), 128'(!BYP));
    step();
    drain();

    // Asynchronous reset between edges with two entries queued.
    cyc(1'b1, 32'h4000_0050, NO_EXC, 1'b0, 1'b0);
    cyc(1'b1, 32'h4000_0054, NO_EXC, 1'b0, 1'b0);
    apply(1'b0, 32'h0, NO_EXC, 1'b0, 1'b0);
    #1;
    chk("pre_rst_count", 128'(count_o), 128'(2));
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 128'(deq_valid_o), 128'(0));
    chk("async_rst_count", 128'(count_o), 128'(0));
    step();
    rst_ni = 1'b1;
    cyc(1'b1, 32'h4000_0060, NO_EXC, 1'b0, 1'b0);
    chk("post_rst_head", 128'(deq_pc_o), 128'(32'h4000_0060));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      exc_type_e e;
      e = ($urandom_range(0, 19) == 0) ? exc_type_e'($urandom_range(1, 3)) : NO_EXC;
      cyc(1'($urandom_range(0, 3) != 0), 32'h4000_1000 + 32'($urandom_range(0, 1023) * 4),
          e, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    chk("flushed_pc_never_seen", 128'(seen_flushed_pc), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
